// File: rtl/pci_arb_pkg.sv
// Shared constants for the central PCI bus arbiter: FSM state encodings
// and a constant-foldable ceiling log2.
package pci_arb_pkg;

    localparam logic [1:0] S_PARK  = 2'd0;
    localparam logic [1:0] S_GAP   = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [1:0] S_BUSY  = 2'd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pci_arb_rr_pick.sv
// Combinational round-robin picker: the first asserted request after
// 'last' (wrapping) wins; 'last' itself has the lowest priority.
module pci_arb_rr_pick #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic                 valid,
    output logic [IDX_W-1:0]     winner
);

    int               idx;
    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the nearest requester after 'last' overwrites the rest
    always_comb begin
        valid  = 1'b0;
        winner = last;
        idx    = 0;
        cand   = '0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx  = (int'(last) + i) % N_MASTERS;
            cand = IDX_W'(idx);
            if (req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end else begin
                valid  = valid;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: REQ_N/GNT_N round-robin with bus parking, hidden
// arbitration during transactions and revocation of unused grants.
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int N_MASTERS    = 4,
    parameter int PARK_MASTER  = 0,
    parameter int IDLE_TIMEOUT = 16,
    localparam int OWNER_W     = (clog2(N_MASTERS) > 1) ? clog2(N_MASTERS) : 1
) (
    input  logic                 PCLK,
    input  logic                 RST_N,
    input  logic [N_MASTERS-1:0] REQ_N,
    input  logic                 FRAME_N,
    input  logic                 IRDY_N,
    output logic [N_MASTERS-1:0] GNT_N,
    output logic [OWNER_W-1:0]   owner,
    output logic                 grant_timeout
);

    localparam int                   TIMER_W    = clog2(IDLE_TIMEOUT + 1);
    localparam logic [OWNER_W-1:0]   PARK_IDX   = OWNER_W'(PARK_MASTER);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(IDLE_TIMEOUT - 1);
    localparam logic [N_MASTERS-1:0] ALL_OFF    = {N_MASTERS{1'b1}};

    function automatic logic [N_MASTERS-1:0] grant_of(input logic [OWNER_W-1:0] idx);
        logic [N_MASTERS-1:0] g;
        g      = ALL_OFF;
        g[idx] = 1'b0;
        return g;
    endfunction

    logic [1:0]           state_r, state_s;
    logic [OWNER_W-1:0]   target_r, target_s;
    logic                 target_park_r, target_park_s;
    logic [OWNER_W-1:0]   last_r, last_s;
    logic [OWNER_W-1:0]   owner_r, owner_s;
    logic [N_MASTERS-1:0] gnt_n_r, gnt_n_s;
    logic [TIMER_W-1:0]   timer_r, timer_s;
    logic                 timeout_r, timeout_s;
    logic                 preempt_r, preempt_s;
    logic                 idle_prev_r;

    logic [N_MASTERS-1:0] req_s;
    logic                 bus_idle_s;
    logic                 start_s;
    logic                 timer_hit_s;
    logic                 others_s;
    logic [OWNER_W-1:0]   pick_last_s;
    logic                 pick_valid_s;
    logic [OWNER_W-1:0]   pick_idx_s;

    assign req_s       = ~REQ_N;
    assign bus_idle_s  = FRAME_N & IRDY_N;
    assign start_s     = idle_prev_r & ~FRAME_N;
    assign timer_hit_s = bus_idle_s & (timer_r == TIMER_LAST);
    assign others_s    = |(req_s & grant_of(owner_r));
    // A revoked grant re-picks as if the revoked master had just been served
    assign pick_last_s = ((state_r == S_GRANT) && timer_hit_s) ? target_r : last_r;

    pci_arb_rr_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (OWNER_W)
    ) u_pick (
        .req    (req_s),
        .last   (pick_last_s),
        .valid  (pick_valid_s),
        .winner (pick_idx_s)
    );

    // Next-state, next-grant and bookkeeping decisions
    always_comb begin
        state_s       = state_r;
        target_s      = target_r;
        target_park_s = target_park_r;
        last_s        = last_r;
        owner_s       = owner_r;
        gnt_n_s       = gnt_n_r;
        timer_s       = timer_r;
        timeout_s     = 1'b0;
        preempt_s     = preempt_r;
        case (state_r)
            S_GAP: begin
                gnt_n_s   = grant_of(target_r);
                timer_s   = '0;
                preempt_s = 1'b0;
                if (target_park_r) begin
                    state_s = S_PARK;
                end else begin
                    state_s = S_GRANT;
                end
            end
            S_PARK: begin
                if (pick_valid_s && (pick_idx_s == PARK_IDX)) begin
                    state_s       = S_GRANT;
                    target_s      = PARK_IDX;
                    target_park_s = 1'b0;
                    timer_s       = '0;
                end else if (pick_valid_s) begin
                    state_s       = S_GAP;
                    target_s      = pick_idx_s;
                    target_park_s = 1'b0;
                    gnt_n_s       = ALL_OFF;
                end else begin
                    state_s = S_PARK;
                end
            end
            S_GRANT: begin
                if (start_s) begin
                    state_s   = S_BUSY;
                    owner_s   = target_r;
                    last_s    = target_r;
                    preempt_s = 1'b0;
                end else if (REQ_N[target_r] || timer_hit_s) begin
                    state_s   = S_GAP;
                    gnt_n_s   = ALL_OFF;
                    timeout_s = ~REQ_N[target_r];
                    if (!REQ_N[target_r]) begin
                        last_s = target_r;
                    end else begin
                        last_s = last_r;
                    end
                    if (pick_valid_s && !(REQ_N[target_r] && (pick_idx_s == target_r))) begin
                        target_s      = pick_idx_s;
                        target_park_s = 1'b0;
                    end else begin
                        target_s      = PARK_IDX;
                        target_park_s = 1'b1;
                    end
                end else if (bus_idle_s) begin
                    timer_s = timer_r + TIMER_W'(1);
                end else begin
                    timer_s = timer_r;
                end
            end
            S_BUSY: begin
                if (bus_idle_s) begin
                    timer_s   = '0;
                    preempt_s = 1'b0;
                    if (preempt_r) begin
                        state_s = S_GRANT;
                        gnt_n_s = grant_of(target_r);
                    end else if (req_s[owner_r]) begin
                        state_s       = S_GRANT;
                        target_s      = owner_r;
                        target_park_s = 1'b0;
                    end else if (!pick_valid_s && (owner_r == PARK_IDX)) begin
                        state_s       = S_PARK;
                        target_s      = PARK_IDX;
                        target_park_s = 1'b1;
                    end else begin
                        state_s       = S_GAP;
                        gnt_n_s       = ALL_OFF;
                        target_s      = pick_valid_s ? pick_idx_s : PARK_IDX;
                        target_park_s = ~pick_valid_s;
                    end
                end else if (!preempt_r && others_s) begin
                    // Hidden arbitration: drop the grant while the owner finishes
                    gnt_n_s       = ALL_OFF;
                    preempt_s     = 1'b1;
                    target_s      = pick_idx_s;
                    target_park_s = 1'b0;
                end else begin
                    state_s = S_BUSY;
                end
            end
            default: begin
                state_s       = S_GAP;
                target_s      = PARK_IDX;
                target_park_s = 1'b1;
                gnt_n_s       = ALL_OFF;
            end
        endcase
    end

    // State, grant and status registers
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= S_GAP;
            target_r      <= PARK_IDX;
            target_park_r <= 1'b1;
            last_r        <= PARK_IDX;
            owner_r       <= PARK_IDX;
            gnt_n_r       <= ALL_OFF;
            timer_r       <= '0;
            timeout_r     <= 1'b0;
            preempt_r     <= 1'b0;
            idle_prev_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            target_r      <= target_s;
            target_park_r <= target_park_s;
            last_r        <= last_s;
            owner_r       <= owner_s;
            gnt_n_r       <= gnt_n_s;
            timer_r       <= timer_s;
            timeout_r     <= timeout_s;
            preempt_r     <= preempt_s;
            idle_prev_r   <= bus_idle_s;
        end
    end

    assign GNT_N         = gnt_n_r;
    assign owner         = owner_r;
    assign grant_timeout = timeout_r;

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter (4 masters, park on 0, 16-cycle timeout).
module tb_pci_arbiter;

    logic       PCLK;
    logic       RST_N;
    logic [3:0] REQ_N;
    logic       FRAME_N;
    logic       IRDY_N;
    logic [3:0] GNT_N;
    logic [1:0] owner;
    logic       grant_timeout;

    typedef struct packed {
        logic [3:0] req_n;
        logic       frame_n;
        logic       irdy_n;
        logic [3:0] gnt_n;
        logic [1:0] owner;
        logic       to;
    } row_t;

    row_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    pci_arbiter #(
        .N_MASTERS    (4),
        .PARK_MASTER  (0),
        .IDLE_TIMEOUT (16)
    ) dut (
        .PCLK          (PCLK),
        .RST_N         (RST_N),
        .REQ_N         (REQ_N),
        .FRAME_N       (FRAME_N),
        .IRDY_N        (IRDY_N),
        .GNT_N         (GNT_N),
        .owner         (owner),
        .grant_timeout (grant_timeout)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic test_reset();
        row_t r;
        RST_N = 1'b1; REQ_N = 4'b1111; FRAME_N = 1'b1; IRDY_N = 1'b1;
        #1 RST_N = 1'b0;
        #1;
        checks++;
        if (GNT_N !== 4'b1111) begin errors++; $display("FAIL reset_gnt got %b want 1111", GNT_N); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
        checks++;
        if (grant_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", grant_timeout); end
        @(posedge PCLK); #1;
        checks++;
        if (GNT_N !== 4'b1111) begin errors++; $display("FAIL reset_held got %b want 1111", GNT_N); end
        RST_N = 1'b1;
        exp_q.push_back('{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0});
        @(posedge PCLK); #1;
        r = exp_q.pop_front();
        checks++;
        if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL reset_park got %b want %b", GNT_N, r.gnt_n); end
        checks++;
        if (owner !== r.owner) begin errors++; $display("FAIL reset_park_owner got %0d want %0d", owner, r.owner); end
    endtask

    task automatic test_single();
        row_t rows[$];
        row_t r;
        rows = '{'{4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0},
                 '{4'b1011, 1'b1, 1'b1, 4'b1011, 2'd0, 1'b0},
                 '{4'b1011, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b0},
                 '{4'b1111, 1'b1, 1'b0, 4'b1011, 2'd2, 1'b0},
                 '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0},
                 '{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd2, 1'b0}};
        for (int i = 0; i < rows.size(); i++) begin
            REQ_N = rows[i].req_n; FRAME_N = rows[i].frame_n; IRDY_N = rows[i].irdy_n;
            exp_q.push_back(rows[i]);
            @(posedge PCLK); #1;
            r = exp_q.pop_front();
            checks++;
            if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL single[%0d] GNT_N got %b want %b", i, GNT_N, r.gnt_n); end
            checks++;
            if (owner !== r.owner) begin errors++; $display("FAIL single[%0d] owner got %0d want %0d", i, owner, r.owner); end
            checks++;
            if (grant_timeout !== r.to) begin errors++; $display("FAIL single[%0d] timeout got %b want %b", i, grant_timeout, r.to); end
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        row_t r;
        rows = '{'{4'b0101, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0},
                 '{4'b0101, 1'b1, 1'b1, 4'b0111, 2'd2, 1'b0}};
        // Each transaction: address+data, last data, idle -> next grant 3,1,3,1
        for (int k = 0; k < 4; k++) begin
            rows.push_back('{4'b0101, 1'b0, 1'b0, (k % 2 == 0) ? 4'b0111 : 4'b1101,
                             (k % 2 == 0) ? 2'd3 : 2'd1, 1'b0});
            rows.push_back('{4'b0101, 1'b1, 1'b0, 4'b1111,
                             (k % 2 == 0) ? 2'd3 : 2'd1, 1'b0});
            rows.push_back('{4'b0101, 1'b1, 1'b1, (k % 2 == 0) ? 4'b1101 : 4'b0111,
                             (k % 2 == 0) ? 2'd3 : 2'd1, 1'b0});
        end
        rows.push_back('{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0});
        rows.push_back('{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd1, 1'b0});
        for (int i = 0; i < rows.size(); i++) begin
            REQ_N = rows[i].req_n; FRAME_N = rows[i].frame_n; IRDY_N = rows[i].irdy_n;
            exp_q.push_back(rows[i]);
            @(posedge PCLK); #1;
            r = exp_q.pop_front();
            checks++;
            if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL rr[%0d] GNT_N got %b want %b", i, GNT_N, r.gnt_n); end
            checks++;
            if (owner !== r.owner) begin errors++; $display("FAIL rr[%0d] owner got %0d want %0d", i, owner, r.owner); end
        end
    endtask

    task automatic test_hidden();
        row_t rows[$];
        row_t r;
        rows = '{'{4'b1101, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0},
                 '{4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0},
                 '{4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0},
                 '{4'b0101, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0},
                 '{4'b0101, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0},
                 '{4'b0101, 1'b1, 1'b0, 4'b1111, 2'd1, 1'b0},
                 '{4'b0111, 1'b1, 1'b1, 4'b0111, 2'd1, 1'b0},
                 '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0},
                 '{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd1, 1'b0}};
        for (int i = 0; i < rows.size(); i++) begin
            REQ_N = rows[i].req_n; FRAME_N = rows[i].frame_n; IRDY_N = rows[i].irdy_n;
            exp_q.push_back(rows[i]);
            @(posedge PCLK); #1;
            r = exp_q.pop_front();
            checks++;
            if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL hidden[%0d] GNT_N got %b want %b", i, GNT_N, r.gnt_n); end
            checks++;
            if (owner !== r.owner) begin errors++; $display("FAIL hidden[%0d] owner got %0d want %0d", i, owner, r.owner); end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        row_t r;
        rows = '{'{4'b1011, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0},
                 '{4'b1011, 1'b1, 1'b1, 4'b1011, 2'd1, 1'b0}};
        for (int k = 0; k < 15; k++) begin
            rows.push_back('{4'b0010, 1'b1, 1'b1, 4'b1011, 2'd1, 1'b0});
        end
        rows.push_back('{4'b0010, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b1});
        rows.push_back('{4'b0010, 1'b1, 1'b1, 4'b0111, 2'd1, 1'b0});
        rows.push_back('{4'b0010, 1'b0, 1'b0, 4'b0111, 2'd3, 1'b0});
        rows.push_back('{4'b0010, 1'b1, 1'b0, 4'b1111, 2'd3, 1'b0});
        rows.push_back('{4'b1010, 1'b1, 1'b1, 4'b1110, 2'd3, 1'b0});
        rows.push_back('{4'b1010, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b0});
        rows.push_back('{4'b1010, 1'b1, 1'b0, 4'b1111, 2'd0, 1'b0});
        rows.push_back('{4'b1011, 1'b1, 1'b1, 4'b1011, 2'd0, 1'b0});
        rows.push_back('{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0});
        rows.push_back('{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0});
        for (int i = 0; i < rows.size(); i++) begin
            REQ_N = rows[i].req_n; FRAME_N = rows[i].frame_n; IRDY_N = rows[i].irdy_n;
            exp_q.push_back(rows[i]);
            @(posedge PCLK); #1;
            r = exp_q.pop_front();
            checks++;
            if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL timeout[%0d] GNT_N got %b want %b", i, GNT_N, r.gnt_n); end
            checks++;
            if (owner !== r.owner) begin errors++; $display("FAIL timeout[%0d] owner got %0d want %0d", i, owner, r.owner); end
            checks++;
            if (grant_timeout !== r.to) begin errors++; $display("FAIL timeout[%0d] pulse got %b want %b", i, grant_timeout, r.to); end
        end
    endtask

    task automatic test_park_request();
        row_t rows[$];
        row_t r;
        rows = '{'{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0},
                 '{4'b1110, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b0},
                 '{4'b1111, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b0},
                 '{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0},
                 '{4'b1101, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0}};
        for (int i = 0; i < rows.size(); i++) begin
            REQ_N = rows[i].req_n; FRAME_N = rows[i].frame_n; IRDY_N = rows[i].irdy_n;
            exp_q.push_back(rows[i]);
            @(posedge PCLK); #1;
            r = exp_q.pop_front();
            checks++;
            if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL park_req[%0d] GNT_N got %b want %b", i, GNT_N, r.gnt_n); end
        end
    endtask

    task automatic test_async_reset();
        row_t rows[$];
        row_t r;
        rows = '{'{4'b1101, 1'b1, 1'b1, 4'b1101, 2'd0, 1'b0},
                 '{4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0}};
        for (int i = 0; i < rows.size(); i++) begin
            REQ_N = rows[i].req_n; FRAME_N = rows[i].frame_n; IRDY_N = rows[i].irdy_n;
            exp_q.push_back(rows[i]);
            @(posedge PCLK); #1;
            r = exp_q.pop_front();
            checks++;
            if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL async[%0d] GNT_N got %b want %b", i, GNT_N, r.gnt_n); end
            checks++;
            if (owner !== r.owner) begin errors++; $display("FAIL async[%0d] owner got %0d want %0d", i, owner, r.owner); end
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (GNT_N !== 4'b1111) begin errors++; $display("FAIL async_gnt got %b want 1111", GNT_N); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL async_owner got %0d want 0", owner); end
        @(posedge PCLK); #1;
        RST_N = 1'b1; REQ_N = 4'b1111; FRAME_N = 1'b1; IRDY_N = 1'b1;
        exp_q.push_back('{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0});
        @(posedge PCLK); #1;
        r = exp_q.pop_front();
        checks++;
        if (GNT_N !== r.gnt_n) begin errors++; $display("FAIL async_repark got %b want %b", GNT_N, r.gnt_n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hidden();
        test_timeout();
        test_park_request();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
